fork_n_avlstrm: RTL and testbench
=================================

FORK_N_AVLSTRM -- requirements
Module: fork_n_avlstrm

Interface
REQ-001 SHALL have parameter WIDTH, default 512, data bus width in bits.
REQ-002 SHALL have parameter NUM_OUT, default 4, number of output channels, legal range 2..16.
REQ-003 SHALL have parameter SEL_W, default 8, width of the destination select field.
REQ-004 SHALL have parameter DROP_OOR, default 1: 1 drops packets with sel>=NUM_OUT; 0 steers them to channel NUM_OUT-1.
REQ-005 SHALL have the clocking and reset ports below; Clk is the only clock; Rst_n is asynchronous and active-low.
- Clk  in  1  sole clock.
- Rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have the input stream ports below.
- in_data  in  WIDTH  beat data.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accept.
- in_sop  in  1  start of packet.
- in_eop  in  1  end of packet.
- in_empty  in  6  empty bytes on EOP beat.
- in_sel  in  SEL_W  destination, meaningful on SOP beat only.
REQ-007 SHALL have the output stream ports below.
- out_data  out  WIDTH  shared data to all channels.
- out_sop / out_eop  out  1 each  shared.
- out_empty  out  6  shared.
- out_valid  out  NUM_OUT  one-hot or zero.
- out_ready  in  NUM_OUT  per-channel ready.
REQ-008 SHALL have the stats ports below.
- stats_pkt  out  NUM_OUT*32  per-channel packets delivered, counted on the EOP handshake; channel i occupies bits [32i+31:32i].
- stats_drop  out  32  packets dropped, out-of-range sel.
- stats_err  out  32  orphan beats: non-SOP beat while IDLE.

Function
REQ-009 SHALL hold one output register stage; each beat appears on out_* exactly 1 cycle after its input handshake.
REQ-010 SHALL drive in_ready = !held_valid || out_ready[held_dest], combinationally, and in_ready=0 while Rst_n is low.
REQ-011 SHALL run FSM states IDLE, FWD and DROP.
- IDLE: an SOP beat with in-range sel, or any sel when DROP_OOR=0, latches cur_dest; go to FWD unless EOP is also set.
- IDLE: an SOP beat with sel>=NUM_OUT when DROP_OOR=1 goes to DROP unless EOP is also set.
- FWD: beats go to cur_dest; an EOP handshake returns to IDLE.
- DROP: beats are consumed and discarded; EOP returns to IDLE.
REQ-012 SHALL ignore in_sel on non-SOP beats; cur_dest is fixed from SOP to EOP, so packets are never split across channels.
REQ-013 SHALL treat an SOP beat seen while in FWD or DROP as ending the current packet implicitly and re-evaluate it as a new SOP; the implicitly ended packet is not counted in stats_pkt.
REQ-014 SHALL consume and discard a non-SOP beat seen in IDLE, increment stats_err, and stay in IDLE.
REQ-015 SHALL in DROP accept every valid beat (in_ready=1 unless the held output beat is stalled), assert no out_valid, and increment stats_drop once per packet on its SOP beat.
REQ-016 SHALL assert at most one out_valid bit per cycle, only bit held_dest.
REQ-017 SHALL hold out_* stable while out_valid[held_dest]=1 and out_ready[held_dest]=0.
REQ-018 SHALL sustain 1 beat/cycle when the destination ready stays high, including back-to-back packets to different channels.
REQ-019 SHALL use 32-bit counters that wrap modulo 2^32 without saturation; a counter update and a wrap in the same cycle are legal.
REQ-020 SHALL give a stalled channel no effect on the others beyond blocking the input: head-of-line blocking is expected behaviour.

Reset
REQ-021 SHALL on Rst_n low set FSM=IDLE, out_valid=0, held_valid=0, cur_dest=0, and all stats=0, with out_data/sop/eop/empty = 0.
REQ-022 SHALL on reset mid-packet discard the partial packet; after reset release, beats before the next SOP are counted in stats_err.

Verification
REQ-023 SHALL pass these scenarios with NUM_OUT=4 and DROP_OOR=1 (scenario 5 overrides DROP_OOR):
1. 3-beat packet with sel=2 and all ready -> out_valid=4'b0100 for 3 consecutive cycles starting 1 cycle after input, then stats_pkt[2]=1.
2. 1-beat SOP+EOP packets with sel 0,1,2,3 back-to-back -> 4 output cycles, one-hot 0001,0010,0100,1000; each stats_pkt=1.
3. Packet with sel=7 (5 beats) -> no out_valid, in_ready=1 throughout, stats_drop=1.
4. sel=1 packet with out_ready[1] low for 10 cycles mid-packet -> in_ready=0 and out_* held stable; the packet then resumes with no loss or duplication.
5. DROP_OOR=0 with sel=9 -> routed to channel 3, stats_pkt[3]=1, stats_drop=0.
6. Non-SOP beat in IDLE -> stats_err=1; reset asserted during beat 2 of 4 -> all outputs and counters 0, and the trailing 2 beats give stats_err=2.

Source files
------------

// File: rtl/fork_n_avlstrm.sv
// fork_n_avlstrm: one-to-N packet fork for an Avalon-ST style stream.
// Each packet is steered whole to the channel named by in_sel on its SOP beat.
// One output register stage sits between input and outputs; the data, sop,
// eop and empty outputs are shared by all channels, and out_valid is one-hot
// (or zero) to mark the owning channel.
//
// Ports
//   Clk, Rst_n        sole clock, asynchronous active-low reset
//   in_*              input beat (data/valid/ready/sop/eop/empty/sel)
//   out_*             shared output beat, per-channel valid/ready
//   stats_pkt         per-channel delivered packets, 32 bits per channel
//   stats_drop        packets dropped for out-of-range select
//   stats_err         orphan (non-SOP while idle) beats
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | between packets; next SOP beat picks the destination
// ST_FWD  | inside a packet, beats go to cur_dest
// ST_DROP | inside an out-of-range packet, beats are consumed and discarded
module fork_n_avlstrm #(
  parameter int WIDTH    = 512,
  parameter int NUM_OUT  = 4,
  parameter int SEL_W    = 8,
  parameter int DROP_OOR = 1
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sop,
  input  logic                   in_eop,
  input  logic [5:0]             in_empty,
  input  logic [SEL_W-1:0]       in_sel,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_sop,
  output logic                   out_eop,
  output logic [5:0]             out_empty,
  output logic [NUM_OUT-1:0]     out_valid,
  input  logic [NUM_OUT-1:0]     out_ready,
  output logic [NUM_OUT*32-1:0]  stats_pkt,
  output logic [31:0]            stats_drop,
  output logic [31:0]            stats_err
);

  localparam int DW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_DROP} state_t;

  state_t          state, state_nx;
  logic            held_valid;
  logic [DW-1:0]   held_dest;
  logic [DW-1:0]   cur_dest;
  logic            held_pop;
  logic            fire;
  logic            sel_ok;
  logic            sop_fwd;
  logic [DW-1:0]   sel_dest;
  logic            beat_fwd;
  logic [DW-1:0]   beat_dest;
  logic            cnt_drop;
  logic            cnt_err;
  logic [31:0]     pkt_cnt [NUM_OUT];

  // The held beat leaves when its own channel is ready; only then (or when the
  // register is empty) can a new beat be taken. Forced low during reset.
  assign held_pop = held_valid && out_ready[held_dest];
  assign in_ready = Rst_n && (!held_valid || out_ready[held_dest]);
  assign fire     = in_valid && in_ready;

  // Out-of-range selects fold onto the last channel when they are not dropped.
  assign sel_ok   = 32'(in_sel) < NUM_OUT;
  assign sop_fwd  = sel_ok || (DROP_OOR == 0);
  assign sel_dest = sel_ok ? in_sel[DW-1:0] : DW'(NUM_OUT - 1);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // An SOP beat always restarts packet tracking, whatever the current state,
  // so a missing EOP ends the previous packet implicitly.
  always_comb begin
    state_nx = state;
    if (fire) begin
      if (in_sop) begin
        if (in_eop)       state_nx = ST_IDLE;
        else if (sop_fwd) state_nx = ST_FWD;
        else              state_nx = ST_DROP;
      end else if (in_eop) begin
        state_nx = ST_IDLE;
      end
    end
  end

  always_comb begin
    beat_fwd  = 1'b0;
    beat_dest = cur_dest;
    cnt_drop  = 1'b0;
    cnt_err   = 1'b0;
    if (fire) begin
      if (in_sop) begin
        if (sop_fwd) begin
          beat_fwd  = 1'b1;
          beat_dest = sel_dest;
        end else begin
          cnt_drop  = 1'b1;
        end
      end else begin
        case (state)
          ST_FWD:  beat_fwd = 1'b1;
          ST_IDLE: cnt_err  = 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cur_dest <= '0;
    end else if (fire && in_sop && sop_fwd) begin
      cur_dest <= sel_dest;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      held_valid <= 1'b0;
      held_dest  <= '0;
      out_data   <= '0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      out_empty  <= '0;
    end else if (fire) begin
      held_valid <= beat_fwd;
      if (beat_fwd) begin
        held_dest <= beat_dest;
        out_data  <= in_data;
        out_sop   <= in_sop;
        out_eop   <= in_eop;
        out_empty <= in_empty;
      end
    end else if (held_pop) begin
      held_valid <= 1'b0;
    end
  end

  always_comb begin
    out_valid = '0;
    if (held_valid) out_valid[held_dest] = 1'b1;
  end

  // Packets are counted as delivered on the output-side EOP handshake, so an
  // implicitly ended packet (no EOP) never counts.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < NUM_OUT; i++) pkt_cnt[i] <= '0;
      stats_drop <= '0;
      stats_err  <= '0;
    end else begin
      if (held_pop && out_eop) pkt_cnt[held_dest] <= pkt_cnt[held_dest] + 32'd1;
      if (cnt_drop) stats_drop <= stats_drop + 32'd1;
      if (cnt_err)  stats_err  <= stats_err + 32'd1;
    end
  end

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_stats
    assign stats_pkt[32*g +: 32] = pkt_cnt[g];
  end

endmodule

// File: tb/tb_fork_n_avlstrm.sv
module tb_fork_n_avlstrm;
  localparam int W  = 32;
  localparam int NO = 4;

  typedef struct packed {
    logic [W-1:0] d;
    logic         sop;
    logic         eop;
    logic [5:0]   emp;
    int           cyc;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_sop = 1'b0;
  logic          in_eop = 1'b0;
  logic [5:0]    in_empty = '0;
  logic [7:0]    in_sel = '0;
  logic          use1 = 1'b0;
  logic [NO-1:0] fixed_rdy = '1;
  logic [NO-1:0] rnd_rdy = '1;
  logic          rand_mode = 1'b0;
  logic [NO-1:0] out_ready;
  assign out_ready = rand_mode ? rnd_rdy : fixed_rdy;

  logic            in_valid0, in_valid1, in_ready0, in_ready1;
  logic [W-1:0]    out_data0, out_data1;
  logic            out_sop0, out_sop1, out_eop0, out_eop1;
  logic [5:0]      out_empty0, out_empty1;
  logic [NO-1:0]   out_valid0, out_valid1;
  logic [NO*32-1:0] stats_pkt0, stats_pkt1;
  logic [31:0]     stats_drop0, stats_drop1, stats_err0, stats_err1;

  assign in_valid0 = in_valid & ~use1;
  assign in_valid1 = in_valid & use1;

  fork_n_avlstrm #(.WIDTH(W), .NUM_OUT(NO), .SEL_W(8), .DROP_OOR(1)) dut0 (
    .Clk(clk), .Rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_sop(in_sop), .in_eop(in_eop), .in_empty(in_empty), .in_sel(in_sel),
    .out_data(out_data0), .out_sop(out_sop0), .out_eop(out_eop0),
    .out_empty(out_empty0), .out_valid(out_valid0), .out_ready(out_ready),
    .stats_pkt(stats_pkt0), .stats_drop(stats_drop0), .stats_err(stats_err0)
  );

  fork_n_avlstrm #(.WIDTH(W), .NUM_OUT(NO), .SEL_W(8), .DROP_OOR(0)) dut1 (
    .Clk(clk), .Rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_sop(in_sop), .in_eop(in_eop), .in_empty(in_empty), .in_sel(in_sel),
    .out_data(out_data1), .out_sop(out_sop1), .out_eop(out_eop1),
    .out_empty(out_empty1), .out_valid(out_valid1), .out_ready(out_ready),
    .stats_pkt(stats_pkt1), .stats_drop(stats_drop1), .stats_err(stats_err1)
  );

  logic            mo_in_ready, mo_sop, mo_eop;
  logic [W-1:0]    mo_data;
  logic [5:0]      mo_empty;
  logic [NO-1:0]   mo_valid;
  logic [NO*32-1:0] mo_pkt;
  logic [31:0]     mo_drop, mo_err;
  assign mo_in_ready = use1 ? in_ready1 : in_ready0;
  assign mo_data     = use1 ? out_data1 : out_data0;
  assign mo_sop      = use1 ? out_sop1 : out_sop0;
  assign mo_eop      = use1 ? out_eop1 : out_eop0;
  assign mo_empty    = use1 ? out_empty1 : out_empty0;
  assign mo_valid    = use1 ? out_valid1 : out_valid0;
  assign mo_pkt      = use1 ? stats_pkt1 : stats_pkt0;
  assign mo_drop     = use1 ? stats_drop1 : stats_drop0;
  assign mo_err      = use1 ? stats_err1 : stats_err0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    rnd_rdy = NO'($urandom);
  end

  // Reference model state: packet position, expected per-channel beats, counters.
  beat_t exp_q[NO][$];
  beat_t obs_q[NO][$];
  int    m_mode = 0;   // 0 between packets, 1 forwarding, 2 discarding
  int    m_dest = 0;
  int    m_pkt[NO];
  int    m_drop = 0;
  int    m_err = 0;
  bit    m_drop_oor = 1'b1;
  int    bad_onehot = 0;
  int    tot_waits = 0;
  int    n_total = 0;
  int    n_pass = 0;
  int    n_fail = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if ((mo_valid & (mo_valid - 1'b1)) != '0) bad_onehot++;
      for (int ch = 0; ch < NO; ch++)
        if (mo_valid[ch] && out_ready[ch])
          obs_q[ch].push_back('{d: mo_data, sop: mo_sop, eop: mo_eop, emp: mo_empty, cyc: cyc});
    end
  end

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_dest = 0;
    foreach (m_pkt[i]) m_pkt[i] = 0;
    m_drop = 0;
    m_err = 0;
    for (int ch = 0; ch < NO; ch++) begin
      exp_q[ch].delete();
      obs_q[ch].delete();
    end
  endtask

  task automatic model_accept(logic [W-1:0] d, logic sop, logic eop, logic [5:0] emp, logic [7:0] sel);
    beat_t b;
    b = '{d: d, sop: sop, eop: eop, emp: emp, cyc: cyc};
    if (sop) begin
      if (sel < NO || !m_drop_oor) begin
        m_dest = (sel < NO) ? int'(sel) : NO - 1;
        m_mode = 1;
        exp_q[m_dest].push_back(b);
        if (eop) m_pkt[m_dest]++;
      end else begin
        m_drop++;
        m_mode = 2;
      end
      if (eop) m_mode = 0;
    end else if (m_mode == 0) begin
      m_err++;
    end else begin
      if (m_mode == 1) begin
        exp_q[m_dest].push_back(b);
        if (eop) m_pkt[m_dest]++;
      end
      if (eop) m_mode = 0;
    end
  endtask

  task automatic send(logic [W-1:0] d, logic sop, logic eop, logic [5:0] emp, logic [7:0] sel);
    int waits = 0;
    in_data = d; in_sop = sop; in_eop = eop; in_empty = emp; in_sel = sel;
    in_valid = 1'b1;
    @(negedge clk);
    while (!mo_in_ready && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    if (!mo_in_ready) chk("send_timeout", mo_in_ready, 1);
    else model_accept(d, sop, eop, emp, sel);
    tot_waits += waits;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    rand_mode = 1'b0;
    fixed_rdy = '1;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    in_valid = 1'b0;
    rand_mode = 1'b0;
    fixed_rdy = '1;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic compare_queues(string tag, bit timing);
    int n;
    for (int ch = 0; ch < NO; ch++) begin
      chk($sformatf("%s_ch%0d_count", tag, ch), obs_q[ch].size(), exp_q[ch].size());
      n = (obs_q[ch].size() < exp_q[ch].size()) ? obs_q[ch].size() : exp_q[ch].size();
      for (int i = 0; i < n; i++) begin
        chk($sformatf("%s_ch%0d_b%0d", tag, ch, i),
            {obs_q[ch][i].d, obs_q[ch][i].sop, obs_q[ch][i].eop, obs_q[ch][i].emp},
            {exp_q[ch][i].d, exp_q[ch][i].sop, exp_q[ch][i].eop, exp_q[ch][i].emp});
        if (timing)
          chk($sformatf("%s_ch%0d_b%0d_lat", tag, ch, i), obs_q[ch][i].cyc, exp_q[ch][i].cyc + 1);
      end
      obs_q[ch].delete();
      exp_q[ch].delete();
    end
  endtask

  task automatic check_stats(string tag);
    for (int ch = 0; ch < NO; ch++)
      chk($sformatf("%s_pkt%0d", tag, ch), mo_pkt[32*ch +: 32], m_pkt[ch]);
    chk({tag, "_drop"}, mo_drop, m_drop);
    chk({tag, "_err"}, mo_err, m_err);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] d [5];
    logic [5:0]   e [5];
    int len;
    bit noeop;

    // Reset state
    #1 rst_n = 1'b0;
    #15;
    chk("rst_valid", mo_valid, 0);
    chk("rst_in_ready", mo_in_ready, 0);
    chk("rst_data", {mo_data, mo_sop, mo_eop, mo_empty}, 0);
    chk("rst_pkt", mo_pkt, 0);
    chk("rst_drop", mo_drop, 0);
    chk("rst_err", mo_err, 0);
    apply_reset();

    // 1: three-beat packet to channel 2, all ready
    for (int i = 0; i < 3; i++) send($urandom, i == 0, i == 2, 6'(i), 8'd2);
    drain();
    compare_queues("s1", 1'b1);
    check_stats("s1");

    // 2: single-beat packets to channels 0..3 back to back
    tot_waits = 0;
    for (int i = 0; i < 4; i++) send($urandom, 1'b1, 1'b1, 6'd0, 8'(i));
    chk("s2_waits", tot_waits, 0);
    drain();
    compare_queues("s2", 1'b1);
    check_stats("s2");

    // 3: out-of-range packet is swallowed without stalling
    tot_waits = 0;
    for (int i = 0; i < 5; i++) send($urandom, i == 0, i == 4, 6'd3, 8'd7);
    chk("s3_waits", tot_waits, 0);
    drain();
    compare_queues("s3", 1'b0);
    check_stats("s3");

    // 4: channel 1 stalls for 10 cycles mid-packet
    for (int i = 0; i < 5; i++) begin
      d[i] = $urandom;
      e[i] = 6'($urandom);
    end
    send(d[0], 1'b1, 1'b0, e[0], 8'd1);
    send(d[1], 1'b0, 1'b0, e[1], 8'd0);
    in_data = d[2]; in_sop = 1'b0; in_eop = 1'b0; in_empty = e[2]; in_sel = 8'd3;
    in_valid = 1'b1;
    fixed_rdy = 4'b1101;
    repeat (10) begin
      @(negedge clk);
      chk("s4_in_ready", mo_in_ready, 0);
      chk("s4_valid", mo_valid, 4'b0010);
      chk("s4_hold", {mo_data, mo_sop, mo_eop, mo_empty}, {d[1], 1'b0, 1'b0, e[1]});
    end
    @(posedge clk); #1;
    fixed_rdy = '1;
    for (int i = 2; i < 5; i++) send(d[i], 1'b0, i == 4, e[i], 8'd2);
    drain();
    compare_queues("s4", 1'b0);
    check_stats("s4");

    // 5: fold out-of-range select onto the last channel
    use1 = 1'b1;
    apply_reset();
    m_drop_oor = 1'b0;
    for (int i = 0; i < 3; i++) send($urandom, i == 0, i == 2, 6'd0, 8'd9);
    drain();
    compare_queues("s5", 1'b0);
    check_stats("s5");
    use1 = 1'b0;
    m_drop_oor = 1'b1;
    apply_reset();

    // 6: orphan beat, then reset in the middle of a packet
    send($urandom, 1'b0, 1'b0, 6'd0, 8'd0);
    drain();
    check_stats("s6a");
    send($urandom, 1'b1, 1'b0, 6'd0, 8'd0);
    in_data = $urandom; in_sop = 1'b0; in_eop = 1'b0; in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("s6_rst_valid", mo_valid, 0);
    chk("s6_rst_in_ready", mo_in_ready, 0);
    chk("s6_rst_data", {mo_data, mo_sop, mo_eop, mo_empty}, 0);
    model_reset();
    check_stats("s6_rst");
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send($urandom, 1'b0, 1'b0, 6'd0, 8'd0);
    send($urandom, 1'b0, 1'b1, 6'd5, 8'd0);
    drain();
    compare_queues("s6", 1'b0);
    check_stats("s6b");

    // 7: randomized traffic with random per-channel backpressure
    apply_reset();
    bad_onehot = 0;
    rand_mode = 1'b1;
    for (int p = 0; p < 80; p++) begin
      if ($urandom_range(0, 9) == 0) begin
        send($urandom, 1'b0, 1'($urandom), 6'($urandom), 8'($urandom_range(0, 7)));
      end else begin
        len = $urandom_range(1, 4);
        noeop = ($urandom_range(0, 7) == 0);
        for (int b = 0; b < len; b++)
          send($urandom, b == 0, (b == len - 1) && !noeop, 6'($urandom), 8'($urandom_range(0, 7)));
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    drain();
    compare_queues("s7", 1'b0);
    check_stats("s7");
    chk("onehot", bad_onehot, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
